// File: rtl/lbus_pkg.sv
// ----------------------------------------------------------------------------
// lbus_pkg
// Shared types and helpers for the AXI-Stream to LBUS transmit adapter.
//   SEG_COUNT / SEG_BYTES / MTY_W : LBUS segment geometry
//   lbus_seg_t                    : one 128-bit LBUS segment with its controls
//   lbus_beat_t                   : one full LBUS beat (SEG_COUNT segments)
//   byte_rev128()                 : byte reversal within a 128-bit segment
// ----------------------------------------------------------------------------
package lbus_pkg;

    localparam int unsigned SEG_COUNT = 4;
    localparam int unsigned SEG_BYTES = 16;
    localparam int unsigned MTY_W     = 4;

    typedef struct packed {
        logic [127:0]     data;
        logic             ena;
        logic             sop;
        logic             eop;
        logic             err;
        logic [MTY_W-1:0] mty;
    } lbus_seg_t;

    typedef lbus_seg_t [SEG_COUNT-1:0] lbus_beat_t;

    // AXIS byte 0 sits in bits [7:0]; LBUS wants it in bits [127:120].
    function automatic logic [127:0] byte_rev128(input logic [127:0] d);
        logic [127:0] r;
        r = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            r[8*b +: 8] = d[8*(15-b) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_2_lbus_tx_maptkeep2mty.sv
// ----------------------------------------------------------------------------
// maptkeep2mty
// Converts a 16-bit segment keep mask into the LBUS empty-byte count:
// mty = 16 - popcount(tkeep), which wraps to 0 for both a full and an
// empty slice.
//   REGISTER : 0 = combinational output, otherwise one register stage
//   clk_i    : clock (used only when REGISTER != 0)
//   rst_i    : synchronous active-high reset (used only when REGISTER != 0)
//   tkeep_i  : segment byte enables
//   mty_o    : empty byte count
// ----------------------------------------------------------------------------
module maptkeep2mty #(
    parameter int unsigned REGISTER = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] tkeep_i,
    output logic [3:0]  mty_o
);

    logic [4:0] cnt;
    logic [3:0] mty_c;

    always_comb begin
        cnt = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            cnt = cnt + 5'(tkeep_i[b]);
        end
        mty_c = 4'(5'd16 - cnt);
    end

    if (REGISTER != 0) begin : g_reg
        logic [3:0] mty_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) mty_q <= '0;
            else       mty_q <= mty_c;
        end
        assign mty_o = mty_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign mty_o          = mty_c;
    end

endmodule

// File: rtl/axis_2_lbus_tx.sv
// ----------------------------------------------------------------------------
// axis_2_lbus_tx
// 512-bit AXI-Stream to 4 x 128-bit LBUS transmit adapter for the 100G MAC.
// One accepted AXIS beat becomes one LBUS beat, one cycle later. An output
// register plus a one-entry skid buffer keep m_lbus_ready off the
// combinational path to s_axis_tready.
//   clk, rst           : clock, synchronous active-high reset
//   s_axis_*           : AXIS slave (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_lbus_data        : segment i in bits [128i+127:128i], byte 0 at MSB
//   m_lbus_ena/sop/eop/err : per-segment controls
//   m_lbus_mty         : 4 bits per segment, empty bytes
//   m_lbus_valid/ready : beat handshake
// Optional (`define LBUS_TX_STATS_EN): stat_pkt_cnt, stat_err_cnt,
// stat_byte_cnt wrap-around transfer counters.
// ----------------------------------------------------------------------------
module axis_2_lbus_tx #(
    parameter int unsigned SEG_COUNT  = 4,
    parameter int unsigned SEG_BYTES  = 16,
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]   m_lbus_data,
    output logic [SEG_COUNT-1:0]    m_lbus_ena,
    output logic [SEG_COUNT-1:0]    m_lbus_sop,
    output logic [SEG_COUNT-1:0]    m_lbus_eop,
    output logic [SEG_COUNT-1:0]    m_lbus_err,
    output logic [4*SEG_COUNT-1:0]  m_lbus_mty,
    output logic                    m_lbus_valid,
    input  logic                    m_lbus_ready
`ifdef LBUS_TX_STATS_EN
    ,
    output logic [31:0]             stat_pkt_cnt,
    output logic [31:0]             stat_err_cnt,
    output logic [47:0]             stat_byte_cnt
`endif
);
    import lbus_pkg::*;

    if (SEG_COUNT != lbus_pkg::SEG_COUNT || SEG_BYTES != lbus_pkg::SEG_BYTES ||
        DATA_WIDTH != SEG_COUNT*SEG_BYTES*8) begin : g_bad_cfg
        $error("axis_2_lbus_tx: only 4 x 16-byte segments / 512-bit data supported");
    end

    typedef enum logic {IDLE, IN_PKT} state_e;

    state_e     state_q, state_d;
    lbus_beat_t out_q, out_d, skid_q, skid_d, in_beat;
    logic       out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic       pkt_err_q, pkt_err_d;

    logic [MTY_W-1:0] seg_mty [SEG_COUNT];
    logic [15:0]      slice;
    logic             any_zero_below, beat_err, err_acc, drop, accept, in_push, drain;
    logic [1:0]       eop_seg;

    for (genvar g = 0; g < 4; g++) begin : g_mty
        maptkeep2mty #(.REGISTER(0)) u_mty (
            .clk_i   (clk),
            .rst_i   (rst),
            .tkeep_i (s_axis_tkeep[16*g +: 16]),
            .mty_o   (seg_mty[g])
        );
    end

    assign s_axis_tready = !skid_valid_q;
    assign accept        = s_axis_tvalid && !skid_valid_q;
    assign drain         = out_valid_q && m_lbus_ready;

    // Build the LBUS beat for the current AXIS input and classify its errors.
    always_comb begin
        in_beat        = '0;
        slice          = '0;
        any_zero_below = 1'b0;
        beat_err       = !s_axis_tlast && (s_axis_tkeep != '1);
        eop_seg        = '0;
        for (int unsigned i = 0; i < SEG_COUNT; i++) begin
            slice              = s_axis_tkeep[16*i +: 16];
            in_beat[i].data    = byte_rev128(s_axis_tdata[128*i +: 128]);
            in_beat[i].ena     = |slice;
            in_beat[i].mty     = seg_mty[i];
            // A contiguous low mask 2^k-1 has no carry overlap with itself.
            if (((slice + 16'd1) & slice) != '0) beat_err = 1'b1;
            if (any_zero_below && (|slice))      beat_err = 1'b1;
            if (!(|slice))                       any_zero_below = 1'b1;
            if (|slice)                          eop_seg = 2'(i);
        end
        err_acc        = pkt_err_q | beat_err;
        drop           = !s_axis_tlast && (s_axis_tkeep == '0);
        in_beat[0].sop = (state_q == IDLE);
        if (s_axis_tlast) begin
            if (s_axis_tkeep == '0) begin
                // Empty last beat still terminates the packet, flagged bad.
                in_beat[0].ena = 1'b1;
                in_beat[0].eop = 1'b1;
                in_beat[0].err = 1'b1;
            end else begin
                in_beat[eop_seg].eop = 1'b1;
                in_beat[eop_seg].err = err_acc | s_axis_tuser;
            end
        end
    end

    // Packet state, sticky error and output/skid buffer control.
    always_comb begin
        state_d      = state_q;
        pkt_err_d    = pkt_err_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        in_push      = accept && !drop;

        if (accept) begin
            if (s_axis_tlast) begin
                state_d   = IDLE;
                pkt_err_d = 1'b0;
            end else begin
                pkt_err_d = err_acc;
                if (!drop) state_d = IN_PKT;
            end
        end

        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_push) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_push) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pkt_err_q    <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkt_err_q    <= pkt_err_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign m_lbus_valid = out_valid_q;

    always_comb begin
        m_lbus_data = '0;
        m_lbus_ena  = '0;
        m_lbus_sop  = '0;
        m_lbus_eop  = '0;
        m_lbus_err  = '0;
        m_lbus_mty  = '0;
        for (int unsigned i = 0; i < SEG_COUNT; i++) begin
            m_lbus_data[128*i +: 128] = out_q[i].data;
            m_lbus_ena[i]             = out_q[i].ena;
            m_lbus_sop[i]             = out_q[i].sop;
            m_lbus_eop[i]             = out_q[i].eop;
            m_lbus_err[i]             = out_q[i].err;
            m_lbus_mty[4*i +: 4]      = out_q[i].mty;
        end
    end

`ifdef LBUS_TX_STATS_EN
    logic [31:0] pkt_cnt_q, err_cnt_q;
    logic [47:0] byte_cnt_q;
    logic [6:0]  xfer_bytes;

    always_comb begin
        xfer_bytes = '0;
        for (int unsigned i = 0; i < SEG_COUNT; i++) begin
            if (out_q[i].ena) xfer_bytes = xfer_bytes + (7'd16 - 7'(out_q[i].mty));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else if (drain) begin
            if (|m_lbus_eop)                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (|(m_lbus_eop & m_lbus_err)) err_cnt_q <= err_cnt_q + 32'd1;
            byte_cnt_q <= byte_cnt_q + 48'(xfer_bytes);
        end
    end

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_err_cnt  = err_cnt_q;
    assign stat_byte_cnt = byte_cnt_q;
`endif

endmodule
